// File: rtl/poly_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module      : poly_mac_seq
//  Description : Dot-product sequencer; streams a[i], b[i], acc into mult_add
//                and accumulates its result over len terms.
//  Revision    : 1.0 - initial release
// ============================================================================
module poly_mac_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ADDR_WIDTH:0]            len,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic [DATA_WIDTH-1:0]          a_data,
    input  logic [DATA_WIDTH-1:0]          b_data,
    output logic [2:0][DATA_WIDTH-1:0]     ma_values,
    output logic                           ma_start,
    input  logic [DATA_WIDTH-1:0]          ma_out,
    input  logic                           ma_ready,
    output logic [DATA_WIDTH-1:0]          result,
    output logic                           done,
    output logic                           busy
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FETCH = 3'd1;
    localparam logic [2:0] c_LOAD  = 3'd2;
    localparam logic [2:0] c_WAIT  = 3'd3;
    localparam logic [2:0] c_GAP   = 3'd4;
    localparam logic [2:0] c_FIN   = 3'd5;

    localparam logic [ADDR_WIDTH:0]   c_LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] c_IDX_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]            r_state;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [DATA_WIDTH-1:0] r_acc;

    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_idx_next;

    // Compare in len's wider domain so len = 2^ADDR_WIDTH terminates at idx all-ones
    assign w_last     = (({1'b0, r_idx} + c_LEN_ONE) == r_len);
    assign w_idx_next = r_idx + c_IDX_ONE;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_len     <= '0;
            r_idx     <= '0;
            r_acc     <= '0;
            mem_addr  <= '0;
            ma_values <= '0;
            ma_start  <= 1'b0;
            result    <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ma_start <= 1'b0;
            done     <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_len    <= len;
                        r_idx    <= '0;
                        r_acc    <= '0;
                        mem_addr <= '0;
                        busy     <= 1'b1;
                        r_state  <= (len == '0) ? c_FIN : c_FETCH;
                    end
                end
                c_FETCH: begin
                    r_state <= c_LOAD;
                end
                c_LOAD: begin
                    ma_values <= {r_acc, b_data, a_data};
                    ma_start  <= 1'b1;
                    r_state   <= c_WAIT;
                end
                c_WAIT: begin
                    // ma_ready is only honoured here; stale completions elsewhere are dropped
                    if (ma_ready) begin
                        r_acc <= ma_out;
                        if (w_last) begin
                            r_state <= c_FIN;
                        end else begin
                            r_idx    <= w_idx_next;
                            mem_addr <= w_idx_next;
                            r_state  <= c_GAP;
                        end
                    end
                end
                c_GAP: begin
                    r_state <= c_FETCH;
                end
                c_FIN: begin
                    result  <= r_acc;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_poly_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_poly_mac_seq
//  Description : Directed bench for poly_mac_seq with RAM and mult_add models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_mac_seq;

    logic              clock;
    logic              reset;
    logic              start;
    logic [8:0]        len;
    logic [7:0]        mem_addr;
    logic [31:0]       a_data;
    logic [31:0]       b_data;
    logic [2:0][31:0]  ma_values;
    logic              ma_start;
    logic [31:0]       ma_out = '0;
    logic              ma_ready = 1'b0;
    logic [31:0]       result;
    logic              done;
    logic              busy;

    poly_mac_seq #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .mem_addr  (mem_addr),
        .a_data    (a_data),
        .b_data    (b_data),
        .ma_values (ma_values),
        .ma_start  (ma_start),
        .ma_out    (ma_out),
        .ma_ready  (ma_ready),
        .result    (result),
        .done      (done),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] a_mem [256];
    logic [31:0] b_mem [256];

    always @(posedge clock) begin
        a_data <= a_mem[mem_addr];
        b_data <= b_mem[mem_addr];
    end

    // mult_add model: no reset, ready pulse lat cycles after start, out = a*b + acc
    int          lat = 2;
    int          m_cnt = 0;
    logic        m_pend = 1'b0;
    logic [31:0] m_val = '0;

    always @(posedge clock) begin
        ma_ready <= 1'b0;
        if (ma_start) begin
            m_pend <= 1'b1;
            m_cnt  <= lat;
            m_val  <= ma_values[0] * ma_values[1] + ma_values[2];
        end else if (m_pend) begin
            if (m_cnt <= 1) begin
                ma_ready <= 1'b1;
                ma_out   <= m_val;
                m_pend   <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    int   done_cnt = 0;
    int   start_cnt = 0;
    int   width_err = 0;
    int   max_addr = 0;
    logic prev_start = 1'b0;

    always @(posedge clock) begin
        if (done) done_cnt++;
        if (ma_start) start_cnt++;
        if (ma_start && prev_start) width_err++;
        prev_start = ma_start;
        if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [8:0] l, input int n,
                          input logic [31:0] exp);
        int d0;
        int s0;
        bit got;
        lat = n;
        d0  = done_cnt;
        s0  = start_cnt;
        start = 1'b1;
        len   = l;
        @(negedge clock);
        start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 8000 && !got; c++) begin
            @(negedge clock);
            if (done) got = 1'b1;
        end
        check({name, "_timeout"}, 64'(got), 64'd1);
        if (got) begin
            check({name, "_result"}, 64'(result), 64'(exp));
            check({name, "_busy_at_done"}, 64'(busy), 64'd0);
        end
        repeat (5) @(negedge clock);
        check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check({name, "_terms"}, 64'(start_cnt - s0), 64'(l));
    endtask

    typedef struct {
        string            name;
        logic [8:0]       len;
        logic [3:0][31:0] a;
        logic [3:0][31:0] b;
        int               lat;
        logic [31:0]      exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        // Packed concatenations list element [3] first, so a[0] is the rightmost value
        vecs[0] = '{"dot4",      9'd4, {32'd4, 32'd3, 32'd2, 32'd1},
                    {32'd8, 32'd7, 32'd6, 32'd5}, 2, 32'd70};
        vecs[1] = '{"wrap1",     9'd1, {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF},
                    {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF}, 3, 32'd1};
        vecs[2] = '{"len3_lat1", 9'd3, {32'd9, 32'd3, 32'd2, 32'd1},
                    {32'd9, 32'd7, 32'd6, 32'd5}, 1, 32'd38};
        vecs[3] = '{"len3_lat9", 9'd3, {32'd9, 32'd3, 32'd2, 32'd1},
                    {32'd9, 32'd7, 32'd6, 32'd5}, 9, 32'd38};
        vecs[4] = '{"sum4",      9'd4, {32'd40, 32'd30, 32'd20, 32'd10},
                    {32'd1, 32'd1, 32'd1, 32'd1}, 3, 32'd100};
        vecs[5] = '{"wrap2",     9'd2, {32'd0, 32'd0, 32'd3, 32'h8000_0000},
                    {32'd0, 32'd0, 32'd4, 32'd2}, 4, 32'd12};

        for (int i = 0; i < 256; i++) begin
            a_mem[i] = '0;
            b_mem[i] = '0;
        end
        reset = 1'b1;
        start = 1'b0;
        len   = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        check("rst_busy",     64'(busy),      64'd0);
        check("rst_done",     64'(done),      64'd0);
        check("rst_result",   64'(result),    64'd0);
        check("rst_mem_addr", 64'(mem_addr),  64'd0);
        check("rst_ma_start", 64'(ma_start),  64'd0);
        check("rst_ma_values_or", 64'(|ma_values), 64'd0);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++) begin
                a_mem[i] = vecs[v].a[i];
                b_mem[i] = vecs[v].b[i];
            end
            run_op(vecs[v].name, vecs[v].len, vecs[v].lat, vecs[v].exp);
        end

        // len = 0: straight to FIN, done on the second edge, no mult_add traffic
        begin
            int d0;
            int s0;
            d0 = done_cnt;
            s0 = start_cnt;
            start = 1'b1;
            len   = 9'd0;
            @(negedge clock);
            start = 1'b0;
            check("len0_busy_fin", 64'(busy), 64'd1);
            check("len0_done_early", 64'(done), 64'd0);
            @(negedge clock);
            check("len0_done", 64'(done), 64'd1);
            check("len0_result", 64'(result), 64'd0);
            check("len0_busy_after", 64'(busy), 64'd0);
            repeat (4) @(negedge clock);
            check("len0_no_ma_start", 64'(start_cnt - s0), 64'd0);
            check("len0_done_pulses", 64'(done_cnt - d0), 64'd1);
        end

        // Second start while busy in WAIT must be ignored
        begin
            int  d0;
            int  s0;
            bit  got;
            for (int i = 0; i < 4; i++) begin
                a_mem[i] = vecs[0].a[i];
                b_mem[i] = vecs[0].b[i];
            end
            lat = 5;
            d0 = done_cnt;
            s0 = start_cnt;
            start = 1'b1;
            len   = 9'd4;
            @(negedge clock);
            start = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 50 && !got; c++) begin
                @(negedge clock);
                if (start_cnt != s0) got = 1'b1;
            end
            check("busy_start_reach_wait", 64'(got), 64'd1);
            start = 1'b1;
            len   = 9'd1;
            @(negedge clock);
            start = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 500 && !got; c++) begin
                @(negedge clock);
                if (done) got = 1'b1;
            end
            check("busy_start_timeout", 64'(got), 64'd1);
            check("busy_start_result", 64'(result), 64'd70);
            repeat (20) @(negedge clock);
            check("busy_start_done_pulses", 64'(done_cnt - d0), 64'd1);
            check("busy_start_terms", 64'(start_cnt - s0), 64'd4);
            check("busy_start_idle", 64'(busy), 64'd0);
        end

        // Full-length vector: mem_addr must walk all the way to 255
        for (int i = 0; i < 256; i++) begin
            a_mem[i] = 32'(i);
            b_mem[i] = 32'd1;
        end
        max_addr = 0;
        run_op("full256", 9'd256, 1, 32'd32640);
        check("full256_max_addr", 64'(max_addr), 64'd255);

        // Reset in WAIT of term 2 of 4; the model's stale ready arrives afterwards
        begin
            int d0;
            int s0;
            bit got;
            for (int i = 0; i < 4; i++) begin
                a_mem[i] = vecs[0].a[i];
                b_mem[i] = vecs[0].b[i];
            end
            lat = 6;
            d0 = done_cnt;
            s0 = start_cnt;
            start = 1'b1;
            len   = 9'd4;
            @(negedge clock);
            start = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge clock);
                if (start_cnt - s0 == 2) got = 1'b1;
            end
            check("midrst_reach_term2", 64'(got), 64'd1);
            @(negedge clock);
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            repeat (15) @(negedge clock);
            check("midrst_done_pulses", 64'(done_cnt - d0), 64'd0);
            check("midrst_result", 64'(result), 64'd0);
            check("midrst_busy", 64'(busy), 64'd0);
            check("midrst_mem_addr", 64'(mem_addr), 64'd0);
            check("midrst_ma_values_or", 64'(|ma_values), 64'd0);
            check("midrst_terms", 64'(start_cnt - s0), 64'd2);
        end

        check("ma_start_width", 64'(width_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
